// File: rtl/quadrature_mixer_decimator.sv
// Quadrature mixer followed by an integrate-and-dump decimator.
// The ADC sample is mixed with the LO cosine (I) and the negated LO sine (Q).
// The products are summed over R_eff samples and then dumped as one
// saturated, optionally right-shifted I/Q pair.
module quadrature_mixer_decimator #(
    parameter int DATA_WIDTH  = 7,
    parameter int ADC_WIDTH   = 12,
    parameter int OUT_WIDTH   = 16,
    parameter int DECIM_WIDTH = 8,
    parameter int SHIFT       = 0
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic                          sample_clk_ce,
    input  logic signed [ADC_WIDTH-1:0]   adc_sample,
    input  logic signed [DATA_WIDTH-1:0]  sinewave,
    input  logic signed [DATA_WIDTH-1:0]  cosinewave,
    input  logic        [DECIM_WIDTH-1:0] decim_ratio,
    output logic signed [OUT_WIDTH-1:0]   i_out,
    output logic signed [OUT_WIDTH-1:0]   q_out,
    output logic                          out_valid
);

    localparam int PW   = ADC_WIDTH + DATA_WIDTH;
    localparam int ACCW = PW + DECIM_WIDTH;

    // Saturation limits expressed at accumulator width so the comparison is exact
    localparam logic signed [ACCW-1:0] SAT_HI =
        {{(ACCW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_LO =
        {{(ACCW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [ADC_WIDTH-1:0]  s1_adc;
    logic signed [DATA_WIDTH-1:0] s1_sin;
    logic signed [DATA_WIDTH-1:0] s1_cos;
    logic                         s1_valid;

    logic signed [PW-1:0] adc_ext;
    logic signed [PW-1:0] sin_ext;
    logic signed [PW-1:0] cos_ext;
    logic signed [PW-1:0] prod_i;
    logic signed [PW-1:0] prod_q;

    logic signed [PW-1:0] s2_pi;
    logic signed [PW-1:0] s2_pq;
    logic                 s2_valid;

    logic signed [ACCW-1:0]  acc_i;
    logic signed [ACCW-1:0]  acc_q;
    logic signed [ACCW-1:0]  sum_i;
    logic signed [ACCW-1:0]  sum_q;
    logic signed [ACCW-1:0]  shifted_i;
    logic signed [ACCW-1:0]  shifted_q;
    logic [DECIM_WIDTH-1:0]  cnt;
    logic [DECIM_WIDTH-1:0]  r_eff;
    logic [DECIM_WIDTH-1:0]  decim_eff;
    logic                    r_load;
    logic                    block_last;

    // Clamp an accumulator-width value into the output range instead of wrapping
    function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [ACCW-1:0] v);
        logic signed [OUT_WIDTH-1:0] r;
        if (v > SAT_HI) begin
            r = SAT_HI[OUT_WIDTH-1:0];
        end else if (v < SAT_LO) begin
            r = SAT_LO[OUT_WIDTH-1:0];
        end else begin
            r = v[OUT_WIDTH-1:0];
        end
        return r;
    endfunction

    // Stage 1: capture the sample and the LO pair together so they stay aligned
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            s1_adc   <= '0;
            s1_sin   <= '0;
            s1_cos   <= '0;
            s1_valid <= 1'b0;
        end else if (sample_clk_ce) begin
            s1_adc   <= adc_sample;
            s1_sin   <= sinewave;
            s1_cos   <= cosinewave;
            s1_valid <= 1'b1;
        end
    end

    // Mixer products at full precision; Q uses the negated sine
    always_comb begin
        adc_ext = {{DATA_WIDTH{s1_adc[ADC_WIDTH-1]}}, s1_adc};
        sin_ext = {{ADC_WIDTH{s1_sin[DATA_WIDTH-1]}}, s1_sin};
        cos_ext = {{ADC_WIDTH{s1_cos[DATA_WIDTH-1]}}, s1_cos};
        prod_i  = adc_ext * cos_ext;
        prod_q  = -(adc_ext * sin_ext);
    end

    // Stage 2: register the products; validity trails stage 1 by one enable
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            s2_pi    <= '0;
            s2_pq    <= '0;
            s2_valid <= 1'b0;
        end else if (sample_clk_ce) begin
            s2_pi    <= prod_i;
            s2_pq    <= prod_q;
            s2_valid <= s1_valid;
        end
    end

    // Running sums including the current product, used both to accumulate and to dump
    always_comb begin
        sum_i      = acc_i + {{DECIM_WIDTH{s2_pi[PW-1]}}, s2_pi};
        sum_q      = acc_q + {{DECIM_WIDTH{s2_pq[PW-1]}}, s2_pq};
        shifted_i  = sum_i >>> SHIFT;
        shifted_q  = sum_q >>> SHIFT;
        decim_eff  = (decim_ratio == '0) ? DECIM_WIDTH'(1) : decim_ratio;
        block_last = (cnt == r_eff - DECIM_WIDTH'(1));
    end

    // Integrate-and-dump: ratio is only re-sampled after reset and at each dump
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            acc_i     <= '0;
            acc_q     <= '0;
            cnt       <= '0;
            r_eff     <= DECIM_WIDTH'(1);
            r_load    <= 1'b1;
            i_out     <= '0;
            q_out     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (r_load) begin
                r_eff  <= decim_eff;
                r_load <= 1'b0;
            end
            if (sample_clk_ce && s2_valid) begin
                if (block_last) begin
                    i_out     <= saturate(shifted_i);
                    q_out     <= saturate(shifted_q);
                    out_valid <= 1'b1;
                    acc_i     <= '0;
                    acc_q     <= '0;
                    cnt       <= '0;
                    r_eff     <= decim_eff;
                end else begin
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                    cnt   <= cnt + DECIM_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_quadrature_mixer_decimator.sv
// Scoreboard bench for quadrature_mixer_decimator.
// Two instances share all stimulus: one with SHIFT=0 and one with SHIFT=3.
// The reference model treats each enabled sample as a product that becomes
// summable two enables later. It sums R_eff of them per block and expects one
// dump on the clock edge that consumes the last product of that block.
module tb_quadrature_mixer_decimator;

    localparam int DW = 7;
    localparam int AW = 12;
    localparam int OW = 16;
    localparam int RW = 8;

    logic                 clk = 1'b0;
    logic                 arst = 1'b1;
    logic                 ce = 1'b0;
    logic signed [AW-1:0] adc = '0;
    logic signed [DW-1:0] sinw = '0;
    logic signed [DW-1:0] cosw = '0;
    logic [RW-1:0]        ratio = RW'(4);

    logic signed [OW-1:0] i0, q0, i3, q3;
    logic                 v0, v3;

    int     errors = 0;
    int     checks = 0;
    longint cyc = 0;

    typedef struct {
        longint i0;
        longint q0;
        longint i3;
        longint q3;
        longint cyc;
    } exp_t;

    exp_t   expq[$];
    longint pipe_i[$];
    longint pipe_q[$];
    longint acc_i = 0;
    longint acc_q = 0;
    int     blk_cnt = 0;
    int     r_cur = 4;
    longint hold_i0 = 0, hold_q0 = 0, hold_i3 = 0, hold_q3 = 0;

    quadrature_mixer_decimator #(
        .DATA_WIDTH(DW), .ADC_WIDTH(AW), .OUT_WIDTH(OW), .DECIM_WIDTH(RW), .SHIFT(0)
    ) dut0 (
        .clk(clk), .arst(arst), .sample_clk_ce(ce), .adc_sample(adc),
        .sinewave(sinw), .cosinewave(cosw), .decim_ratio(ratio),
        .i_out(i0), .q_out(q0), .out_valid(v0)
    );

    quadrature_mixer_decimator #(
        .DATA_WIDTH(DW), .ADC_WIDTH(AW), .OUT_WIDTH(OW), .DECIM_WIDTH(RW), .SHIFT(3)
    ) dut3 (
        .clk(clk), .arst(arst), .sample_clk_ce(ce), .adc_sample(adc),
        .sinewave(sinw), .cosinewave(cosw), .decim_ratio(ratio),
        .i_out(i3), .q_out(q3), .out_valid(v3)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Edge counter used to pin each expected dump to a specific clock edge
    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint sat(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int eff(input int r);
        return (r == 0) ? 1 : r;
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one clock's worth of inputs and advance the reference model if enabled
    task automatic applyStimulus(input bit c, input int a, input int s, input int co, input int r);
        exp_t e;
        @(posedge clk);
        #1;
        ce    = c;
        adc   = AW'(a);
        sinw  = DW'(s);
        cosw  = DW'(co);
        ratio = RW'(r);
        if (c) begin
            pipe_i.push_back(longint'(a) * longint'(co));
            pipe_q.push_back(-(longint'(a) * longint'(s)));
            if (pipe_i.size() > 2) begin
                acc_i += pipe_i.pop_front();
                acc_q += pipe_q.pop_front();
                blk_cnt++;
                if (blk_cnt == r_cur) begin
                    e.i0  = sat(acc_i);
                    e.q0  = sat(acc_q);
                    e.i3  = sat(acc_i >>> 3);
                    e.q3  = sat(acc_q >>> 3);
                    e.cyc = cyc + 1;
                    expq.push_back(e);
                    acc_i   = 0;
                    acc_q   = 0;
                    blk_cnt = 0;
                    r_cur   = eff(r);
                end
            end
        end
    endtask

    task automatic applyReset(input int r);
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("pending_before_reset", longint'(expq.size()), 0);
        arst  = 1'b1;
        ce    = 1'b0;
        ratio = RW'(r);
        repeat (2) @(posedge clk);
        #1;
        arst = 1'b0;
        expq.delete();
        pipe_i.delete();
        pipe_q.delete();
        acc_i   = 0;
        acc_q   = 0;
        blk_cnt = 0;
        r_cur   = eff(r);
    endtask

    function automatic int rndAdc();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    function automatic int rndLo();
        return int'($urandom_range(0, 127)) - 64;
    endfunction

    // Monitor: compare each dump against the scoreboard, otherwise outputs must hold
    always @(negedge clk) begin
        exp_t e;
        if (arst) begin
            checkOutput("reset_i0", longint'(i0), 0);
            checkOutput("reset_q3", longint'(q3), 0);
            checkOutput("reset_valid", longint'({v0, v3}), 0);
            hold_i0 = 0; hold_q0 = 0; hold_i3 = 0; hold_q3 = 0;
        end else if (v0 || v3) begin
            checkOutput("valid_pair", longint'(v0 && v3), 1);
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: got out_valid with empty scoreboard, expected none (edge %0d)", cyc);
            end else begin
                e = expq.pop_front();
                checkOutput("dump_edge", cyc, e.cyc);
                checkOutput("i_out_s0", longint'(i0), e.i0);
                checkOutput("q_out_s0", longint'(q0), e.q0);
                checkOutput("i_out_s3", longint'(i3), e.i3);
                checkOutput("q_out_s3", longint'(q3), e.q3);
                hold_i0 = e.i0; hold_q0 = e.q0; hold_i3 = e.i3; hold_q3 = e.q3;
            end
        end else begin
            checkOutput("hold_i0", longint'(i0), hold_i0);
            checkOutput("hold_q0", longint'(q0), hold_q0);
            checkOutput("hold_i3", longint'(i3), hold_i3);
            checkOutput("hold_q3", longint'(q3), hold_q3);
        end
    end

    // Directed scenarios followed by a randomized soak
    initial begin
        int r;
        int a, s, co;

        $display("[TB] start");

        // Constant tone, R=4: 25200 every 4th enable starting at the 6th
        applyReset(4);
        repeat (14) applyStimulus(1'b1, 100, 0, 63, 4);

        // R=1 saturation on both rails
        applyReset(1);
        repeat (4) applyStimulus(1'b1, 1000, 0, 63, 1);
        repeat (4) applyStimulus(1'b1, -2048, -64, 0, 1);

        // R=0 behaves as R=1
        applyReset(0);
        repeat (10) applyStimulus(1'b1, rndAdc(), rndLo(), rndLo(), 0);

        // R=8 with SHIFT=3 gives 6300
        applyReset(8);
        repeat (18) applyStimulus(1'b1, 100, 0, 63, 8);

        // Enable every 3rd clock, R=2, with junk on the inputs between enables
        applyReset(2);
        repeat (12) begin
            applyStimulus(1'b1, rndAdc(), rndLo(), rndLo(), 2);
            repeat (2) applyStimulus(1'b0, rndAdc(), rndLo(), rndLo(), 2);
        end

        // Reset in the middle of a block discards the partial sum
        applyReset(4);
        repeat (4) applyStimulus(1'b1, rndAdc(), rndLo(), rndLo(), 4);
        applyReset(4);
        repeat (10) applyStimulus(1'b1, rndAdc(), rndLo(), rndLo(), 4);

        // Ratio 4 -> 2 mid-block: current block still uses 4
        applyReset(4);
        repeat (4) applyStimulus(1'b1, rndAdc(), rndLo(), rndLo(), 4);
        repeat (10) applyStimulus(1'b1, rndAdc(), rndLo(), rndLo(), 2);

        // Randomized enables, data and occasional ratio changes
        r = int'($urandom_range(0, 5));
        applyReset(r);
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 15) == 0) r = int'($urandom_range(0, 6));
            a  = rndAdc();
            s  = rndLo();
            co = rndLo();
            applyStimulus($urandom_range(0, 3) != 0, a, s, co, r);
        end

        repeat (4) applyStimulus(1'b0, 0, 0, 0, r);
        @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", longint'(expq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/quadrature_mixer_decimator.md
QUADRATURE_MIXER_DECIMATOR -- requirements
Module: quadrature_mixer_decimator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 7, meaning signed width of the sine/cosine LO inputs.
REQ-002 SHALL have parameter ADC_WIDTH, default 12, meaning signed width of the input sample.
REQ-003 SHALL have parameter OUT_WIDTH, default 16, meaning signed width of the I/Q outputs.
REQ-004 SHALL have parameter DECIM_WIDTH, default 8, meaning width of the decimation ratio input.
REQ-005 SHALL have parameter SHIFT, default 0, meaning arithmetic right shift applied to the dumped sum.
REQ-006 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-007 SHALL have port arst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port sample_clk_ce  input  1  sample-rate clock enable; all pipeline and accumulator advance only when high.
REQ-009 SHALL have port adc_sample  input  ADC_WIDTH  signed input sample, time-aligned with sinewave/cosinewave on the same ce.
REQ-010 SHALL have port sinewave  input  DATA_WIDTH  signed LO sine from the quarter-wave NCO.
REQ-011 SHALL have port cosinewave  input  DATA_WIDTH  signed LO cosine from the quarter-wave NCO.
REQ-012 SHALL have port decim_ratio  input  DECIM_WIDTH  unsigned decimation ratio R; 0 treated as 1.
REQ-013 SHALL have port i_out  output  OUT_WIDTH  signed decimated in-phase result.
REQ-014 SHALL have port q_out  output  OUT_WIDTH  signed decimated quadrature result.
REQ-015 SHALL have port out_valid  output  1  one-clk strobe marking new i_out/q_out.

Function
REQ-016 SHALL, on ce, register adc_sample, sinewave, cosinewave into stage-1 registers (stage-1 valid set).
REQ-017 SHALL, on ce, compute products P_I = s1_adc*s1_cos and P_Q = -(s1_adc*s1_sin), each signed ADC_WIDTH+DATA_WIDTH bits, into stage-2 registers (stage-2 valid follows stage-1 valid).
REQ-018 SHALL hold accumulators of width ADC_WIDTH+DATA_WIDTH+DECIM_WIDTH, full precision, no internal wrap for R <= 2^DECIM_WIDTH-1.
REQ-019 SHALL, on ce with stage-2 valid, add P_I/P_Q to accumulators and increment a sample counter; products are not accumulated before stage-2 valid (first two ce after reset ignored).
REQ-020 SHALL, on the ce where counter == R_eff-1 (R_eff = max(decim_ratio,1)), form S = accumulator + product, load i_out/q_out with saturate(S >>> SHIFT) to OUT_WIDTH, clear accumulators to 0 and counter to 0.
REQ-021 SHALL saturate to +2^(OUT_WIDTH-1)-1 / -2^(OUT_WIDTH-1); no wrap.
REQ-022 SHALL assert out_valid for exactly one clk cycle, on the clk edge the dump is registered, regardless of ce width.
REQ-023 SHALL sample decim_ratio only at dump boundaries (and after reset); a mid-block change takes effect for the next block.
REQ-024 SHALL hold all state, outputs unchanged and out_valid low while sample_clk_ce is low.
REQ-025 SHALL have latency: first dump on the (R_eff+2)th ce after reset.

Reset
REQ-026 SHALL, while arst high, clear i_out, q_out, out_valid, accumulators, counter, stage registers and valids to 0, and latch R_eff from decim_ratio at release.
REQ-027 SHALL, on arst mid-block, discard the partial sum; no out_valid until a full new block of R_eff products.

Verification
REQ-028 SHALL pass: R=4, SHIFT=0, adc=100, cos=63, sin=0 constant, ce every clk -> i_out=25200, q_out=0, out_valid every 4th clk from 6th ce.
REQ-029 SHALL pass: R=1, adc=1000, cos=63 -> i_out=32767 (saturated); adc=-2048, sin=-64 -> q_out=-32768.
REQ-030 SHALL pass: R=0 -> identical to R=1; R=8, SHIFT=3, adc=100, cos=63 -> i_out=6300.
REQ-031 SHALL pass: ce every 3rd clk, R=2 -> out_valid width 1 clk, values equal to ce-every-clk case.
REQ-032 SHALL pass: arst pulse after 2 of 4 samples -> outputs 0, next out_valid after 4 full products with correct sum.
REQ-033 SHALL pass: decim_ratio 4->2 mid-block -> current block dumps after 4, following blocks after 2.
